// File: rtl/alu_cmd_sequencer.sv
// Command sequencer wrapped around one 4-bit combinational ALU: it issues each operation, captures the result, and presents it.
// Optional sticky overflow flag is built when ALU_SEQ_STICKY_OVF_EN is defined.
module alu_cmd_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic             cmd_acc_sel,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_m,
   input  logic [WIDTH-1:0] alu_r,
   input  logic             alu_ovf,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_ovf,
   output logic [WIDTH-1:0] acc,
   output logic [CNT_W-1:0] op_count
`ifdef ALU_SEQ_STICKY_OVF_EN
   ,
   output logic             ovf_sticky
`endif
);

   // state | meaning
   // IDLE  | waiting for a command, cmd_ready=1
   // ISSUE | ALU inputs stable, result captured at the end of this cycle
   // HOLD  | result presented, waiting for res_ready
   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   state_t           state;
   logic [WIDTH-1:0] res_nxt;
   logic             ovf_nxt;

   // Compare leaves the top bit undriven, and overflow is only meaningful for add/sub.
   always_comb begin
      res_nxt = alu_r;
      if (alu_m == 3'd2) res_nxt[WIDTH-1] = 1'b0;
      ovf_nxt = ((alu_m == 3'd0) || (alu_m == 3'd1)) ? alu_ovf : 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         res_valid <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_m     <= '0;
         res_data  <= '0;
         res_ovf   <= 1'b0;
         acc       <= '0;
         op_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  alu_m     <= cmd_op;
                  alu_a     <= cmd_acc_sel ? acc : cmd_a;
                  alu_b     <= cmd_b;
                  cmd_ready <= 1'b0;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               res_data  <= res_nxt;
               res_ovf   <= ovf_nxt;
               if (alu_m != 3'd2) acc <= res_nxt;
               res_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (res_ready) begin
                  op_count  <= op_count + CNT_W'(1);
                  res_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               res_valid <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

`ifdef ALU_SEQ_STICKY_OVF_EN
   // Accepting not-a on the accumulator clears the flag and takes priority over a set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_sticky <= 1'b0;
      else if ((state == IDLE) && cmd_valid && (cmd_op == 3'd5) && cmd_acc_sel)
         ovf_sticky <= 1'b0;
      else if ((state == ISSUE) && ovf_nxt)
         ovf_sticky <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural 4-bit ALU attached.
// Build with ALU_SEQ_STICKY_OVF_EN defined to also check the sticky overflow flag.
module tb_alu_cmd_sequencer;
   localparam int WIDTH = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [2:0]       cmd_op = '0;
   logic [WIDTH-1:0] cmd_a = '0;
   logic [WIDTH-1:0] cmd_b = '0;
   logic             cmd_acc_sel = 1'b0;
   logic [WIDTH-1:0] alu_a, alu_b;
   logic [2:0]       alu_m;
   logic [WIDTH-1:0] alu_r;
   wire              alu_ovf;
   logic             ovf_calc;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [WIDTH-1:0] res_data;
   logic             res_ovf;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] op_count;
`ifdef ALU_SEQ_STICKY_OVF_EN
   logic             ovf_sticky;
`endif

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc_sel(cmd_acc_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_m(alu_m),
      .alu_r(alu_r), .alu_ovf(alu_ovf),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_ovf(res_ovf),
      .acc(acc), .op_count(op_count)
`ifdef ALU_SEQ_STICKY_OVF_EN
      , .ovf_sticky(ovf_sticky)
`endif
   );

   // Behavioural ALU: compare drives bit 3 high and non-arith ops drive junk overflow.
   always_comb begin
      alu_r    = '0;
      ovf_calc = 1'b1;
      case (alu_m)
         3'd0: {ovf_calc, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
         3'd1: begin alu_r = alu_a - alu_b; ovf_calc = (alu_a < alu_b); end
         3'd2: alu_r = {1'b1, alu_a > alu_b, alu_a == alu_b, alu_a < alu_b};
         3'd3: alu_r = alu_a & alu_b;
         3'd4: alu_r = alu_a | alu_b;
         3'd5: alu_r = ~alu_a;
         3'd6: alu_r = alu_a + 4'd1;
         default: alu_r = alu_a - 4'd1;
      endcase
   end
   assign alu_ovf = (alu_m == 3'd3) ? 1'bz : ovf_calc;

   typedef struct {
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic       sel;
      logic [3:0] res;
      logic       ovf;
      logic [3:0] acc;
   } vec_t;

   typedef struct {
      logic [3:0] res;
      logic       ovf;
      logic [3:0] acc;
   } exp_t;

   exp_t       sb[$];
   vec_t       tbl[15];
   int         n_cmp = 0;
   int         n_err = 0;
   logic [3:0] m_acc = '0;
   logic [7:0] m_cnt = '0;
   logic       m_sticky = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_reset_values();
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_alu_m", alu_m, 0);
      check("rst_res_data", res_data, 0);
      check("rst_acc", acc, 0);
      check("rst_op_count", op_count, 0);
      check("rst_res_ovf", res_ovf, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_cmd_ready", cmd_ready, 1);
`ifdef ALU_SEQ_STICKY_OVF_EN
      check("rst_ovf_sticky", ovf_sticky, 0);
`endif
   endtask

   function automatic logic [4:0] ref_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      logic [4:0] s;
      case (op)
         3'd0: s = {1'b0, a} + {1'b0, b};
         3'd1: s = {a < b, a - b};
         3'd2: s = {2'b00, a > b, a == b, a < b};
         3'd3: s = {1'b0, a & b};
         3'd4: s = {1'b0, a | b};
         3'd5: s = {1'b0, ~a};
         3'd6: s = {1'b0, a + 4'd1};
         default: s = {1'b0, a - 4'd1};
      endcase
      return s;
   endfunction

   task automatic run_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic sel, input logic [3:0] res, input logic ovf,
                          input logic [3:0] acc_e, input int hold);
      logic [3:0] exp_a;
      exp_t       e;
      int         waited;
      @(negedge clk);
      check("idle_cmd_ready", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc_sel = sel;
      @(posedge clk);
      sb.push_back('{res, ovf, acc_e});
      exp_a = sel ? m_acc : a;
      if (op == 3'd5 && sel) m_sticky = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("issue_alu_a", alu_a, exp_a);
      check("issue_alu_b", alu_b, b);
      check("issue_alu_m", alu_m, op);
      check("issue_cmd_ready", cmd_ready, 0);
      check("issue_res_valid", res_valid, 0);
`ifdef ALU_SEQ_STICKY_OVF_EN
      check("accept_ovf_sticky", ovf_sticky, m_sticky);
`endif
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!res_valid && waited < 8);
      if (!res_valid) begin
         n_cmp++; n_err++;
         $display("FAIL res_valid_timeout: got 0 expected 1 at %0t", $time);
         sb.delete();
         return;
      end
      e = sb.pop_front();
      m_acc = e.acc;
      if (e.ovf) m_sticky = 1'b1;
      check("res_data", res_data, e.res);
      check("res_ovf", res_ovf, e.ovf);
      check("acc", acc, e.acc);
`ifdef ALU_SEQ_STICKY_OVF_EN
      check("hold_ovf_sticky", ovf_sticky, m_sticky);
`endif
      for (int k = 0; k < hold; k++) begin
         cmd_valid = 1'b1; cmd_op = ~op; cmd_a = ~a;
         @(negedge clk);
         check("bp_res_valid", res_valid, 1);
         check("bp_res_data", res_data, e.res);
         check("bp_res_ovf", res_ovf, e.ovf);
         check("bp_cmd_ready", cmd_ready, 0);
         check("bp_op_count", op_count, m_cnt);
         check("bp_alu_m", alu_m, op);
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk);
      m_cnt++;
      @(negedge clk);
      res_ready = 1'b0;
      check("op_count", op_count, m_cnt);
      check("done_res_valid", res_valid, 0);
      check("done_cmd_ready", cmd_ready, 1);
   endtask

   initial begin
      tbl[0]  = '{3'd0, 4'd5,  4'd3, 1'b0, 4'd8,  1'b0, 4'd8};
      tbl[1]  = '{3'd0, 4'd9,  4'd8, 1'b0, 4'd1,  1'b1, 4'd1};
      tbl[2]  = '{3'd3, 4'd15, 4'd6, 1'b0, 4'd6,  1'b0, 4'd6};
      tbl[3]  = '{3'd0, 4'd7,  4'd0, 1'b0, 4'd7,  1'b0, 4'd7};
      tbl[4]  = '{3'd6, 4'd0,  4'd0, 1'b1, 4'd8,  1'b0, 4'd8};
      tbl[5]  = '{3'd2, 4'd3,  4'd5, 1'b0, 4'd1,  1'b0, 4'd8};
      tbl[6]  = '{3'd2, 4'd5,  4'd5, 1'b0, 4'd2,  1'b0, 4'd8};
      tbl[7]  = '{3'd2, 4'd6,  4'd2, 1'b0, 4'd4,  1'b0, 4'd8};
      tbl[8]  = '{3'd7, 4'd0,  4'd0, 1'b1, 4'd7,  1'b0, 4'd7};
      tbl[9]  = '{3'd1, 4'd2,  4'd5, 1'b0, 4'd13, 1'b1, 4'd13};
      tbl[10] = '{3'd4, 4'd4,  4'd9, 1'b0, 4'd13, 1'b0, 4'd13};
      tbl[11] = '{3'd5, 4'd0,  4'd0, 1'b1, 4'd2,  1'b0, 4'd2};
      tbl[12] = '{3'd0, 4'd15, 4'd1, 1'b0, 4'd0,  1'b1, 4'd0};
      tbl[13] = '{3'd0, 4'd1,  4'd2, 1'b0, 4'd3,  1'b0, 4'd3};
      tbl[14] = '{3'd5, 4'd0,  4'd0, 1'b1, 4'd12, 1'b0, 4'd12};

      #1 rst_n = 1'b0;
      #1 check_reset_values();
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i])
         run_cmd(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sel,
                 tbl[i].res, tbl[i].ovf, tbl[i].acc, (i == 3) ? 4 : 0);

      // Reset pulled low while a result is being held.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 4'd3; cmd_b = 4'd4; cmd_acc_sel = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_res_valid", res_valid, 1);
      check("pre_rst_res_data", res_data, 7);
      #2 rst_n = 1'b0;
      #1 check_reset_values();
      m_acc = '0; m_cnt = '0; m_sticky = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic long enough to wrap op_count.
      for (int n = 0; n < 260; n++) begin
         logic [2:0] op;
         logic [3:0] a, b, ea;
         logic       sel;
         logic [4:0] r;
         op  = 3'($urandom_range(0, 7));
         a   = 4'($urandom_range(0, 15));
         b   = 4'($urandom_range(0, 15));
         sel = 1'($urandom_range(0, 1));
         ea  = sel ? m_acc : a;
         r   = ref_op(op, ea, b);
         run_cmd(op, a, b, sel, r[3:0], r[4], (op == 3'd2) ? m_acc : r[3:0], 0);
      end
      check("op_count_wrapped", op_count, 8'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
